// File: rtl/mem_access_defs.sv
// Shared state encodings and memory-protocol constants for the load/store front end.
package mem_access_defs;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // Next count: advance only while below the all-ones ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front end: validates byte-addressed word requests, drives the
// data memory's enable/rw/word-address protocol and returns a held response.
module mem_access_ctrl
    import mem_access_defs::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_wData,
    input  logic [DATA_W-1:0] mem_rData,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  err_count
);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rd_inc, wr_inc, err_inc;
    logic              addr_err;

    // Misaligned, or beyond the last word of the memory.
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);

    // Next-state and latch-update logic for the request/response sequence.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        rd_inc  = 1'b0;
        wr_inc  = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (addr_err) begin
                        // Word address left untouched so mem_add keeps its last issued value.
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = req_addr[ADDR_W+1:2];
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q == MEM_WRITE) begin
                    wr_inc  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Memory registered the read on the ISSUE edge; take it now.
                rdata_d = mem_rData;
                rd_inc  = 1'b1;
                state_d = S_RESP;
            end
            default: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and latched request/response fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode only registered state, never req_* directly.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid & err_q;
        mem_enable = (state_q == S_ISSUE);
        mem_rw     = mem_enable ? we_q : MEM_READ;
        mem_add    = addr_q;
        mem_wData  = (mem_enable && (we_q == MEM_WRITE)) ? wdata_q : '0;
    end

    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_inc),
        .count (rd_count)
    );

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_inc),
        .count (wr_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .count (err_count)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 1024x32 data memory.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_enable, mem_rw;
    logic [9:0]  mem_add;
    logic [31:0] mem_wData;
    logic [31:0] mem_rData;
    logic [15:0] rd_count, wr_count, err_count;

    // Second instance with 2-bit counters shares the stimulus and memory read data.
    logic        s_req_ready, s_resp_valid, s_resp_err, s_mem_enable, s_mem_rw;
    logic [31:0] s_resp_rdata, s_mem_wData;
    logic [9:0]  s_mem_add;
    logic [1:0]  s_rd_count, s_wr_count, s_err_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [1024];

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(10), .DATA_W(32), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_add(mem_add),
        .mem_wData(mem_wData), .mem_rData(mem_rData), .rd_count(rd_count),
        .wr_count(wr_count), .err_count(err_count)
    );

    mem_access_ctrl #(.ADDR_W(10), .DATA_W(32), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_rdata(s_resp_rdata),
        .resp_err(s_resp_err), .mem_enable(s_mem_enable), .mem_rw(s_mem_rw),
        .mem_add(s_mem_add), .mem_wData(s_mem_wData), .mem_rData(mem_rData),
        .rd_count(s_rd_count), .wr_count(s_wr_count), .err_count(s_err_count)
    );

    // Data memory: reset-initialised, registered read data.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h1;
            mem[1] <= 32'h10;
            mem[2] <= 32'h11;
            mem_rData <= 32'h0;
        end else if (mem_enable) begin
            if (mem_rw) mem[mem_add] <= mem_wData;
            else mem_rData <= mem[mem_add];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Present one request, wait (bounded) for resp_valid; leaves the DUT in RESP.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err,
                        output logic en_seen, output logic [9:0] add_seen,
                        output logic rw_seen);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        lat = 1;
        en_seen = 1'b0;
        add_seen = '0;
        rw_seen = 1'b0;
        while (!resp_valid && lat < 10) begin
            if (mem_enable) begin
                en_seen  = 1'b1;
                add_seen = mem_add;
                rw_seen  = mem_rw;
            end
            tick();
            lat++;
        end
        if (mem_enable) en_seen = 1'b1;
        rd  = resp_rdata;
        err = resp_err;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_enable, mem_rw} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=10000",
                     {req_ready, resp_valid, resp_err, mem_enable, mem_rw});
        end
        checks++;
        if ({resp_rdata, mem_wData, mem_add, rd_count, wr_count, err_count} !== '0) begin
            failures++;
            $display("FAIL reset_data rdata=%h wdata=%h add=%0d cnt=%0d/%0d/%0d want all 0",
                     resp_rdata, mem_wData, mem_add, rd_count, wr_count, err_count);
        end
    endtask

    task automatic test_read();
        apply_reset();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; req_wdata = 32'h0;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({mem_enable, mem_rw, mem_add, resp_valid} !== {1'b1, 1'b0, 10'd1, 1'b0}) begin
            failures++;
            $display("FAIL read_issue en=%b rw=%b add=%0d rv=%b want en=1 rw=0 add=1 rv=0",
                     mem_enable, mem_rw, mem_add, resp_valid);
        end
        tick();
        checks++;
        if ({mem_enable, resp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL read_wait en=%b rv=%b want 0 0", mem_enable, resp_valid);
        end
        tick();
        checks++;
        if ({resp_valid, resp_err, resp_rdata, rd_count} !== {1'b1, 1'b0, 32'h10, 16'd1}) begin
            failures++;
            $display("FAIL read_resp rv=%b err=%b rdata=%h rd=%0d want 1 0 00000010 1",
                     resp_valid, resp_err, resp_rdata, rd_count);
        end
        tick();
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL read_release rv=%b rr=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic err, en, rw; logic [9:0] add;
        apply_reset();
        send(1'b1, 32'hFFC, 32'hDEADBEEF, lat, rd, err, en, add, rw);
        checks++;
        if ({lat, rd, err, en, add, rw} !== {32'd2, 32'h0, 1'b0, 1'b1, 10'd1023, 1'b1}) begin
            failures++;
            $display("FAIL store_resp lat=%0d rdata=%h err=%b en=%b add=%0d rw=%b want 2 0 0 1 1023 1",
                     lat, rd, err, en, add, rw);
        end
        tick();
        checks++;
        if (mem[1023] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL store_mem got=%h want=deadbeef", mem[1023]);
        end
        send(1'b0, 32'hFFC, 32'h0, lat, rd, err, en, add, rw);
        checks++;
        if ({lat, rd, err, en, add, rw} !== {32'd3, 32'hDEADBEEF, 1'b0, 1'b1, 10'd1023, 1'b0}) begin
            failures++;
            $display("FAIL load_back lat=%0d rdata=%h err=%b en=%b add=%0d rw=%b want 3 deadbeef 0 1 1023 0",
                     lat, rd, err, en, add, rw);
        end
        tick();
        checks++;
        if ({wr_count, rd_count, err_count} !== {16'd1, 16'd1, 16'd0}) begin
            failures++;
            $display("FAIL store_load_cnt wr=%0d rd=%0d err=%0d want 1 1 0",
                     wr_count, rd_count, err_count);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic err, en, rw; logic [9:0] add;
        apply_reset();
        send(1'b0, 32'h2, 32'h0, lat, rd, err, en, add, rw);
        checks++;
        if ({lat, rd, err, en} !== {32'd1, 32'h0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL err_misalign lat=%0d rdata=%h err=%b en=%b want 1 0 1 0",
                     lat, rd, err, en);
        end
        tick();
        send(1'b1, 32'h1000, 32'hCAFEF00D, lat, rd, err, en, add, rw);
        checks++;
        if ({lat, rd, err, en} !== {32'd1, 32'h0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL err_range lat=%0d rdata=%h err=%b en=%b want 1 0 1 0",
                     lat, rd, err, en);
        end
        tick();
        checks++;
        if ({err_count, rd_count, wr_count, mem[0], mem[1]} !==
            {16'd2, 16'd0, 16'd0, 32'h1, 32'h10}) begin
            failures++;
            $display("FAIL err_side err=%0d rd=%0d wr=%0d m0=%h m1=%h want 2 0 0 1 10",
                     err_count, rd_count, wr_count, mem[0], mem[1]);
        end
    endtask

    task automatic test_back_pressure();
        int lat; logic [31:0] rd; logic err, en, rw; logic [9:0] add;
        int bad;
        apply_reset();
        resp_ready = 1'b0;
        send(1'b0, 32'h8, 32'h0, lat, rd, err, en, add, rw);
        checks++;
        if ({lat, rd, add} !== {32'd3, 32'h11, 10'd2}) begin
            failures++;
            $display("FAIL bp_load lat=%0d rdata=%h add=%0d want 3 00000011 2", lat, rd, add);
        end
        // Intruding store must be ignored while the response is held.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'hBAD0BAD0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({resp_valid, resp_rdata, resp_err, req_ready, mem_enable} !==
                {1'b1, 32'h11, 1'b0, 1'b0, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold unstable_cycles=%0d want 0 (rv=%b rdata=%h rr=%b)",
                     bad, resp_valid, resp_rdata, req_ready);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        checks++;
        if ({resp_valid, req_ready, wr_count, rd_count, mem[0]} !==
            {1'b0, 1'b1, 16'd0, 16'd1, 32'h1}) begin
            failures++;
            $display("FAIL bp_release rv=%b rr=%b wr=%0d rd=%0d m0=%h want 0 1 0 1 1",
                     resp_valid, req_ready, wr_count, rd_count, mem[0]);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        // Leaves rd_count=1 from the previous test so the clear is observable.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({resp_valid, mem_enable, rd_count, wr_count, err_count} !== '0) begin
            failures++;
            $display("FAIL rst_async rv=%b en=%b cnt=%0d/%0d/%0d want all 0",
                     resp_valid, mem_enable, rd_count, wr_count, err_count);
        end
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid || !req_ready) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_idle bad_cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_saturation();
        int lat; logic [31:0] rd; logic err, en, rw; logic [9:0] add;
        logic [1:0] want;
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            send(1'b0, 32'h0, 32'h0, lat, rd, err, en, add, rw);
            tick();
            want = (i >= 3) ? 2'd3 : 2'(i);
            checks++;
            if ({s_rd_count, rd_count, rd} !== {want, 16'(i), 32'h1}) begin
                failures++;
                $display("FAIL sat_load%0d sat_rd=%0d rd=%0d rdata=%h want %0d %0d 1",
                         i, s_rd_count, rd_count, rd, want, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_store_load();
        test_errors();
        test_back_pressure();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
